// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: shared definitions for the PS/2 keyboard receiver.
//   KbWidth           - scan byte width
//   FrameLen          - bits per PS/2 frame (start, 8 data, parity, stop)
//   TimeoutCycDefault - default inter-edge timeout in clk cycles
//   IDLE/RECV/CHECK   - receiver FSM state encodings
//   oddParity()       - reduction helper for the optional parity check
package ps2_kb_pkg;

  localparam int KbWidth           = 8;
  localparam int FrameLen          = 11;
  localparam int TimeoutCycDefault = 50000;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  // Returns 1 when the data+parity bits contain an odd number of ones.
  function automatic logic oddParity(input logic [KbWidth:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// kb_fifo: receive FIFO for keyboard scan bytes.
//   clk, rst     - system clock, asynchronous active-high reset
//   push, din    - write strobe and byte; ignored when full unless a pop coincides
//   pop          - read strobe; ignored when empty
//   dout         - head entry, 0 when empty (combinational)
//   empty, full  - occupancy flags
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == {(AW+1){1'b0}});
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush = push & (~full | doPop);
  assign dout   = empty ? {WIDTH{1'b0}} : mem[rdPtr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= {AW{1'b0}};
      rdPtr <= {AW{1'b0}};
      count <= {(AW+1){1'b0}};
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb.sv
// ps2_kb: PS/2 keyboard receiver with scan-byte FIFO.
//   clk, rst   - system clock, asynchronous active-high reset
//   ps2_clk    - keyboard clock (asynchronous, idles high)
//   ps2_data   - keyboard data (asynchronous, idles high)
//   sig_rd_kb  - pop strobe, may be combinational from kb_ready
//   kb_data    - byte at FIFO head, 0 when empty
//   kb_ready   - FIFO not empty
//   kb_ovf     - sticky: a valid frame was dropped on a full FIFO
// Build option KB_PARITY_CHK_EN: also reject frames without odd parity.
module ps2_kb
  import ps2_kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               sig_rd_kb,
  output logic [KbWidth-1:0] kb_data,
  output logic               kb_ready,
  output logic               kb_ovf
);

  localparam int ToW = $clog2(TIMEOUT_CYC + 1);
  localparam int SrW = FrameLen - 1;

  logic           clkMeta, clkSync, clkDly;
  logic           dataMeta, dataSync;
  logic           clkFall;
  logic [1:0]     state;
  logic [3:0]     bitCnt;
  logic [SrW-1:0] shiftReg;
  logic [ToW-1:0] toCnt;
  logic           frameOk;
  logic           push;
  logic           pop;
  logic           fifoEmpty;
  logic           fifoFull;

  // Two-flop synchronizers plus a delayed clock stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkMeta  <= 1'b1;
      clkSync  <= 1'b1;
      clkDly   <= 1'b1;
      dataMeta <= 1'b1;
      dataSync <= 1'b1;
    end else begin
      clkMeta  <= ps2_clk;
      clkSync  <= clkMeta;
      clkDly   <= clkSync;
      dataMeta <= ps2_data;
      dataSync <= dataMeta;
    end
  end

  assign clkFall = clkDly & ~clkSync;

  // Frame receiver: bitCnt names the next bit (1..10) after the start bit.
  // shiftReg ends as {stop, parity, data[7:0]} after bit 10.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= 4'd0;
      shiftReg <= {SrW{1'b0}};
      toCnt    <= {ToW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          toCnt  <= {ToW{1'b0}};
          bitCnt <= 4'd0;
          if (clkFall && !dataSync) begin
            state  <= RECV;
            bitCnt <= 4'd1;
          end
        end
        RECV: begin
          if (clkFall) begin
            toCnt    <= {ToW{1'b0}};
            shiftReg <= {dataSync, shiftReg[SrW-1:1]};
            if (bitCnt == 4'd10) begin
              state  <= CHECK;
              bitCnt <= 4'd0;
            end else begin
              bitCnt <= bitCnt + 4'd1;
            end
          end else if (toCnt == ToW'(TIMEOUT_CYC - 1)) begin
            // Keyboard stalled mid-frame: drop what was collected.
            state    <= IDLE;
            bitCnt   <= 4'd0;
            toCnt    <= {ToW{1'b0}};
            shiftReg <= {SrW{1'b0}};
          end else begin
            toCnt <= toCnt + ToW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          bitCnt <= 4'd0;
          toCnt  <= {ToW{1'b0}};
        end
      endcase
    end
  end

  // Frame validity: stop bit, optionally odd parity over data+parity.
  always_comb begin
    frameOk = shiftReg[SrW-1];
`ifdef KB_PARITY_CHK_EN
    frameOk = frameOk & oddParity(shiftReg[KbWidth:0]);
`else
    frameOk = frameOk & 1'b1;
`endif
  end

  assign push     = (state == CHECK) & frameOk;
  assign pop      = sig_rd_kb & ~fifoEmpty;
  assign kb_ready = ~fifoEmpty;

  // Sticky overflow: set only when a valid byte is actually dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_ovf <= 1'b0;
    end else if (push && fifoFull && !pop) begin
      kb_ovf <= 1'b1;
    end
  end

  kb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KbWidth)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shiftReg[KbWidth-1:0]),
    .dout  (kb_data),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

endmodule
